// File: rtl/ads8688_scan_sched.sv
// rtl/ads8688_scan_sched.sv - round-robin ADS8688 manual-channel scan scheduler
module ads8688_scan_sched #(
   parameter int          NCH         = 8,
   parameter logic [15:0] CMD_BASE    = 16'hC000,
   parameter logic [15:0] CMD_STEP    = 16'h0400,
   parameter logic [15:0] NOOP_CMD    = 16'h0000,
   parameter int          INTER_FRAME = 2,
   parameter int          TIMEOUT     = 4096
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           scan_en,
   input  logic [NCH-1:0] ch_mask,
   input  logic [31:0]    period,
   output logic           manchn_start,
   output logic [15:0]    chsel,
   input  logic           manchn_done,
   input  logic [15:0]    ch_data,
   output logic           smp_valid,
   output logic [2:0]     smp_ch,
   output logic [15:0]    smp_data,
   output logic           scan_done,
   output logic           busy,
   output logic           err_timeout
);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, GAP, HOLD} state_t;

   state_t         state, state_n;
   logic [NCH-1:0] work_mask, work_mask_n;
   logic [2:0]     cur_ch, cur_ch_n;
   logic [2:0]     prev_ch, prev_ch_n;
   logic           first_frame, first_frame_n;
   logic           flush, flush_n;
   logic           done_q;
   logic [15:0]    gap_cnt, gap_cnt_n;
   logic [31:0]    wd_cnt, wd_cnt_n;
   logic [31:0]    per_cnt, per_cnt_n;
   logic           manchn_start_n, smp_valid_n, scan_done_n, busy_n, err_timeout_n;
   logic [15:0]    chsel_n, smp_data_n;
   logic [2:0]     smp_ch_n;
   logic           done_edge, per_expired, scan_go;

   // lowest enabled channel still pending in a mask
   function automatic logic [2:0] lowest_ch(input logic [NCH-1:0] m);
      logic [2:0] idx;
      idx = '0;
      for (int i = NCH - 1; i >= 0; i--)
         if (m[i]) idx = 3'(i);
      return idx;
   endfunction

   assign done_edge   = manchn_done & ~done_q;
   // period 0 means back-to-back; the counter saturates so expiry is sticky
   assign per_expired = (period == 32'd0) || (per_cnt >= period - 32'd1);

   // next-state, datapath and registered-output values
   always_comb begin
      state_n        = state;
      work_mask_n    = work_mask;
      cur_ch_n       = cur_ch;
      prev_ch_n      = prev_ch;
      first_frame_n  = first_frame;
      flush_n        = flush;
      gap_cnt_n      = gap_cnt;
      wd_cnt_n       = wd_cnt;
      per_cnt_n      = (per_cnt == '1) ? per_cnt : per_cnt + 32'd1;
      chsel_n        = chsel;
      smp_data_n     = smp_data;
      smp_ch_n       = smp_ch;
      manchn_start_n = 1'b0;
      smp_valid_n    = 1'b0;
      scan_done_n    = 1'b0;
      err_timeout_n  = err_timeout;
      scan_go        = 1'b0;

      case (state)
         IDLE, HOLD: begin
            if (scan_en && per_expired) begin
               per_cnt_n     = '0;
               work_mask_n   = ch_mask;
               first_frame_n = 1'b1;
               scan_go       = (ch_mask != '0);
               state_n       = (ch_mask != '0) ? LAUNCH : IDLE;
            end else if (state == HOLD && !scan_en) begin
               state_n = IDLE;
            end
         end
         WAIT_DONE: begin
            wd_cnt_n = wd_cnt + 32'd1;
            if (done_edge) begin
               // the first frame returns the result of whatever was selected before
               if (!first_frame) begin
                  smp_valid_n = 1'b1;
                  smp_data_n  = ch_data;
                  smp_ch_n    = prev_ch;
               end
               first_frame_n          = 1'b0;
               prev_ch_n              = cur_ch;
               work_mask_n[cur_ch]    = 1'b0;
               if (flush) begin
                  scan_done_n = 1'b1;
                  state_n     = HOLD;
               end else begin
                  gap_cnt_n = 16'(INTER_FRAME - 1);
                  state_n   = GAP;
               end
            end else if (wd_cnt >= 32'(TIMEOUT - 1)) begin
               err_timeout_n = 1'b1;
               state_n       = IDLE;
            end
         end
         GAP: begin
            if (gap_cnt == 16'd0) begin
               scan_go = 1'b1;
               state_n = LAUNCH;
            end else begin
               gap_cnt_n = gap_cnt - 16'd1;
            end
         end
         default: state_n = WAIT_DONE;
      endcase

      // command word and start pulse are registered so they appear in the LAUNCH cycle
      if (scan_go) begin
         manchn_start_n = 1'b1;
         wd_cnt_n       = 32'd1;
         flush_n        = (work_mask_n == '0);
         cur_ch_n       = lowest_ch(work_mask_n);
         chsel_n        = flush_n ? NOOP_CMD : CMD_BASE + CMD_STEP * 16'(cur_ch_n);
      end

      busy_n = (state_n == LAUNCH) || (state_n == WAIT_DONE) || (state_n == GAP);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         work_mask    <= '0;
         cur_ch       <= '0;
         prev_ch      <= '0;
         first_frame  <= 1'b0;
         flush        <= 1'b0;
         done_q       <= 1'b0;
         gap_cnt      <= '0;
         wd_cnt       <= '0;
         per_cnt      <= '1;
         manchn_start <= 1'b0;
         chsel        <= NOOP_CMD;
         smp_valid    <= 1'b0;
         smp_ch       <= '0;
         smp_data     <= '0;
         scan_done    <= 1'b0;
         busy         <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         state        <= state_n;
         work_mask    <= work_mask_n;
         cur_ch       <= cur_ch_n;
         prev_ch      <= prev_ch_n;
         first_frame  <= first_frame_n;
         flush        <= flush_n;
         done_q       <= manchn_done;
         gap_cnt      <= gap_cnt_n;
         wd_cnt       <= wd_cnt_n;
         per_cnt      <= per_cnt_n;
         manchn_start <= manchn_start_n;
         chsel        <= chsel_n;
         smp_valid    <= smp_valid_n;
         smp_ch       <= smp_ch_n;
         smp_data     <= smp_data_n;
         scan_done    <= scan_done_n;
         busy         <= busy_n;
         err_timeout  <= err_timeout_n;
      end
   end

endmodule

// File: tb/tb_ads8688_scan_sched.sv
// tb/tb_ads8688_scan_sched.sv - scoreboard bench for ads8688_scan_sched
`timescale 1ns/1ps
module tb_ads8688_scan_sched;

   localparam int NCH     = 8;
   localparam int TIMEOUT = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic        scan_en;
   logic [7:0]  ch_mask;
   logic [31:0] period;
   logic        manchn_start;
   logic [15:0] chsel;
   logic        manchn_done = 1'b0;
   logic [15:0] ch_data = 16'h0;
   logic        smp_valid;
   logic [2:0]  smp_ch;
   logic [15:0] smp_data;
   logic        scan_done;
   logic        busy;
   logic        err_timeout;

   ads8688_scan_sched dut (
      .clk(clk), .rst(rst), .scan_en(scan_en), .ch_mask(ch_mask), .period(period),
      .manchn_start(manchn_start), .chsel(chsel), .manchn_done(manchn_done),
      .ch_data(ch_data), .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data),
      .scan_done(scan_done), .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct packed {
      logic [2:0]  ch;
      logic [15:0] data;
      logic        last;
   } smp_t;

   logic [15:0] exp_cmd_q[$];
   logic [15:0] spi_data_q[$];
   smp_t        exp_smp_q[$];

   // SPI controller model: answers each start with a done pulse after a random latency
   logic        spi_mute = 1'b0;
   logic        spi_act = 1'b0;
   int          spi_lat = 0;
   int          spi_hold = 0;
   logic [15:0] spi_d = 16'h0;
   logic [15:0] spi_cmd = 16'h0;
   always @(negedge clk) begin
      if (rst) begin
         spi_act     = 1'b0;
         manchn_done = 1'b0;
      end else begin
         if (spi_act) begin
            if (spi_lat > 0) begin
               check("chsel_stable", 32'(chsel), 32'(spi_cmd));
               spi_lat--;
            end else if (spi_hold > 0) begin
               manchn_done = 1'b1;
               ch_data     = spi_d;
               spi_hold--;
            end else begin
               manchn_done = 1'b0;
               spi_act     = 1'b0;
            end
         end
         if (manchn_start) begin
            manchn_done = 1'b0;
            n_vec++;
            if (exp_cmd_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_start: chsel %0h, expected no start (cycle %0d)", chsel, cyc);
            end else begin
               logic [15:0] ec;
               ec = exp_cmd_q.pop_front();
               if (chsel !== ec) begin
                  n_bad++;
                  $display("FAIL chsel: got %0h, expected %0h (cycle %0d)", chsel, ec, cyc);
               end
            end
            spi_d    = (spi_data_q.size() != 0) ? spi_data_q.pop_front() : 16'($urandom);
            spi_cmd  = chsel;
            spi_act  = !spi_mute;
            spi_lat  = $urandom_range(3, 10);
            spi_hold = $urandom_range(1, 3);
         end
      end
   end

   // output monitor: pops the scoreboard whenever a sample is presented
   int   start_cnt = 0;
   int   last_start_cyc = 0;
   int   open_cyc[$];
   int   done_cyc[$];
   logic busy_q = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         busy_q = 1'b0;
      end else begin
         if (manchn_start) begin
            start_cnt++;
            last_start_cyc = cyc;
            if (!busy_q) open_cyc.push_back(cyc);
         end
         if (smp_valid) begin
            if (exp_smp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_sample: ch %0d data %0h, expected none (cycle %0d)", smp_ch, smp_data, cyc);
            end else begin
               smp_t e;
               e = exp_smp_q.pop_front();
               check("smp_ch", 32'(smp_ch), 32'(e.ch));
               check("smp_data", 32'(smp_data), 32'(e.data));
               check("scan_done", 32'(scan_done), 32'(e.last));
            end
         end else if (scan_done) begin
            n_vec++;
            n_bad++;
            $display("FAIL stray_scan_done: scan_done 1 without smp_valid (cycle %0d)", cyc);
         end
         if (scan_done) done_cyc.push_back(cyc);
         busy_q = busy;
      end
   end

   task automatic wait_starts(input string name, input int target, input int budget);
      int n;
      n = 0;
      while (start_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_start_seen"}, 32'(start_cnt >= target), 32'd1);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_cmd_q.size() != 0 || exp_smp_q.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_completed"}, 32'(n < budget), 32'd1);
      repeat (8) @(negedge clk);
      check({name, "_cmd_left"}, 32'(exp_cmd_q.size()), 32'd0);
      check({name, "_smp_left"}, 32'(exp_smp_q.size()), 32'd0);
   endtask

   // reference: k enabled channels -> k+1 frames, samples (ch[j-1], data[j]) in ascending order
   task automatic run_scan(input string name, input logic [7:0] mask, input int drop_after,
                           input bit rnd, input logic [15:0] dbase, input logic [15:0] dstep,
                           input int nscans);
      int          chs[$];
      logic [15:0] d;
      smp_t        e;
      int          base;
      for (int s = 0; s < nscans; s++) begin
         chs = {};
         for (int i = 0; i < NCH; i++) begin
            if (mask[i]) begin
               chs.push_back(i);
               exp_cmd_q.push_back(16'hC000 + 16'(i) * 16'h0400);
            end
         end
         exp_cmd_q.push_back(16'h0000);
         for (int j = 0; j <= chs.size(); j++) begin
            d = rnd ? 16'($urandom) : dbase + 16'(j) * dstep;
            spi_data_q.push_back(d);
            if (j > 0) begin
               e.ch   = 3'(chs[j-1]);
               e.data = d;
               e.last = (j == chs.size());
               exp_smp_q.push_back(e);
            end
         end
      end
      base = start_cnt;
      ch_mask = mask;
      scan_en = 1'b1;
      wait_starts(name, base + drop_after, 20000);
      scan_en = 1'b0;
      ch_mask = 8'($urandom);
      wait_idle(name, 20000);
      check({name, "_data_left"}, 32'(spi_data_q.size()), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL global_time_limit: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] m;
      int         k, bad, n0, d0, n;

      rst = 1'b1; scan_en = 1'b0; ch_mask = 8'h00; period = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_manchn_start", 32'(manchn_start), 32'd0);
      check("rst_chsel", 32'(chsel), 32'h0000);
      check("rst_smp_valid", 32'(smp_valid), 32'd0);
      check("rst_smp_ch", 32'(smp_ch), 32'd0);
      check("rst_smp_data", 32'(smp_data), 32'd0);
      check("rst_scan_done", 32'(scan_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err_timeout", 32'(err_timeout), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_scan("mask02", 8'h02, 1, 1'b0, 16'h1111, 16'h1111, 1);
      run_scan("maskA5", 8'hA5, 1, 1'b0, 16'h0001, 16'h0001, 1);

      ch_mask = 8'h00;
      scan_en = 1'b1;
      bad = 0;
      repeat (500) begin
         @(negedge clk);
         if (manchn_start || busy || smp_valid) bad++;
      end
      scan_en = 1'b0;
      check("zero_mask_activity", 32'(bad), 32'd0);

      run_scan("mask0F_drop", 8'h0F, 2, 1'b1, 16'h0, 16'h0, 1);

      for (int r = 0; r < 12; r++) begin
         m = 8'($urandom_range(1, 255));
         k = $countones(m);
         run_scan("random", m, $urandom_range(1, k + 1), 1'b1, 16'h0, 16'h0, 1);
      end

      period = 32'd5000;
      n0 = open_cyc.size();
      run_scan("period5000", 8'h01, 3, 1'b1, 16'h0, 16'h0, 2);
      check("period5000_scans", 32'(open_cyc.size() - n0), 32'd2);
      if (open_cyc.size() >= n0 + 2)
         check("period5000_spacing", 32'(open_cyc[n0+1] - open_cyc[n0]), 32'd5000);

      period = 32'd10;
      n0 = open_cyc.size();
      d0 = done_cyc.size();
      run_scan("period10", 8'h01, 3, 1'b1, 16'h0, 16'h0, 2);
      check("period10_scans", 32'(open_cyc.size() - n0), 32'd2);
      if (open_cyc.size() >= n0 + 2 && done_cyc.size() >= d0 + 1)
         check("period10_back_to_back", 32'(open_cyc[n0+1] - done_cyc[d0]), 32'd1);
      period = 32'd0;

      spi_mute = 1'b1;
      exp_cmd_q.push_back(16'hD000);
      ch_mask = 8'h10;
      scan_en = 1'b1;
      wait_starts("timeout", start_cnt + 1, 200);
      scan_en = 1'b0;
      n = 0;
      while (!err_timeout && n < TIMEOUT + 100) begin
         @(negedge clk);
         n++;
      end
      check("timeout_flag", 32'(err_timeout), 32'd1);
      check("timeout_latency", 32'(cyc - last_start_cyc), 32'(TIMEOUT));
      check("timeout_busy", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      spi_mute = 1'b0;
      spi_data_q.delete();
      run_scan("after_timeout", 8'h36, 1, 1'b1, 16'h0, 16'h0, 1);
      check("timeout_sticky", 32'(err_timeout), 32'd1);

      spi_mute = 1'b1;
      exp_cmd_q.push_back(16'hC800);
      ch_mask = 8'h0C;
      scan_en = 1'b1;
      wait_starts("reset_mid", start_cnt + 1, 200);
      scan_en = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_mid_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("reset_mid_start", 32'(manchn_start), 32'd0);
      check("reset_mid_chsel", 32'(chsel), 32'h0000);
      check("reset_mid_busy", 32'(busy), 32'd0);
      check("reset_mid_err", 32'(err_timeout), 32'd0);
      check("reset_mid_valid", 32'(smp_valid), 32'd0);
      check("reset_mid_smp_ch", 32'(smp_ch), 32'd0);
      check("reset_mid_smp_data", 32'(smp_data), 32'd0);
      rst = 1'b0;
      spi_mute = 1'b0;
      spi_data_q.delete();
      repeat (5) @(negedge clk);

      run_scan("after_reset", 8'h81, 1, 1'b1, 16'h0, 16'h0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ads8688_scan_sched.md
# ads8688_scan_sched

Round-robin scan scheduler for the ADS8688 manual-channel SPI controller (`ADS8688_manchn`). It walks an enabled-channel mask and issues one manual-channel command frame per channel, plus one trailing flush frame. It realigns the ADS8688's one-frame result pipeline so every output sample carries the channel it was converted from, and it repeats scans at a programmable period. It sits between system control logic and the single `ADS8688_manchn` instance, driving that instance's `manchn_start`/`chsel` inputs and consuming its `manchn_done`/`ch_data` outputs.

## Interface
- `NCH`, 8: number of ADC channels (mask width).
- `CMD_BASE`, 16'hC000: manual-channel command for channel 0.
- `CMD_STEP`, 16'h0400: command increment per channel index (ch n = `CMD_BASE` + n·`CMD_STEP`).
- `NOOP_CMD`, 16'h0000: command sent in the flush frame.
- `INTER_FRAME`, 2: idle cycles between the detected done edge and the next `manchn_start`; minimum 1.
- `TIMEOUT`, 4096: maximum cycles to wait for done after a start.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `scan_en`  in  1  level; while high, scans repeat.
- `ch_mask`  in  NCH  enabled channels; sampled at scan start.
- `period`  in  32  cycles from one scan start to the next; 0 means back-to-back.
- `manchn_start`  out  1  one-cycle start pulse to the SPI controller.
- `chsel`  out  16  command word to the SPI controller.
- `manchn_done`  in  1  frame-complete from the SPI controller; rising edge detected internally.
- `ch_data`  in  16  frame result; valid at the done rising edge.
- `smp_valid`  out  1  one-cycle sample strobe.
- `smp_ch`  out  3  channel of `smp_data`.
- `smp_data`  out  16  converted sample.
- `scan_done`  out  1  one-cycle pulse, coincident with the last `smp_valid` of a scan.
- `busy`  out  1  high from scan start to scan end.
- `err_timeout`  out  1  sticky watchdog flag.

## Operation
- States are IDLE, LAUNCH, WAIT_DONE, GAP and HOLD.
- **IDLE**
  - On `scan_en`=1 with the period timer expired, latch `ch_mask` into a working mask and restart the period timer.
  - If the latched mask is nonzero, go to LAUNCH. If it is zero, skip the scan: no frames, no `scan_done`, stay IDLE until the next period expiry.
- **LAUNCH** (one cycle)
  - Drive `chsel` to the lowest set channel remaining in the working mask, or to `NOOP_CMD` if the mask is exhausted (flush frame).
  - Pulse `manchn_start`, record the channel in `cur_ch`, then go to WAIT_DONE.
- **WAIT_DONE**
  - `chsel` is held constant.
  - On the done rising edge:
    - If this is the first frame of the scan, discard `ch_data` (stale data from the previous selection).
    - Otherwise emit `smp_data`=`ch_data` and `smp_ch`=`prev_ch`.
    - Then `prev_ch`←`cur_ch` and clear that bit from the working mask.
  - If this was the flush frame, assert `scan_done` with the final sample and go to HOLD. Otherwise go to GAP.
- **GAP**: wait `INTER_FRAME` cycles, then go to LAUNCH.
- **HOLD**: wait for the period timer to expire, then re-evaluate as in IDLE. If `scan_en` is 0, go to IDLE.
- A scan of k enabled channels issues k+1 frames and produces exactly k samples, in ascending channel order.
- Period timer:
  - Counts up from each scan start.
  - It is expired when count ≥ `period`-1, saturating.
  - If the scan is longer than `period`, the next scan starts from HOLD on the cycle after `scan_done`.
- Deasserting `scan_en` mid-scan does not abort; the current scan, including its flush frame, completes.
- Changes to `ch_mask` or `period` mid-scan are ignored until the next scan start (`period` is read live only for expiry).
- Watchdog:
  - Counts cycles in WAIT_DONE.
  - At `TIMEOUT` without a done edge, set `err_timeout`, drop the scan (no `scan_done`, no sample), and go to IDLE.
  - `err_timeout` is cleared only by `rst`; scanning continues afterwards.
- `busy` is high in LAUNCH, WAIT_DONE and GAP.

## Timing
- Reset values: state IDLE; `manchn_start`, `smp_valid`, `scan_done`, `busy`, `err_timeout` are 0; `chsel`=`NOOP_CMD`; `smp_ch`=0; `smp_data`=0; working mask 0; period timer expired.
- `rst` takes effect at the next clock edge and is honoured in any state, including mid-frame. The SPI controller is reset separately by the system.
- All outputs are registered. `chsel` becomes valid in the same cycle `manchn_start` is high and is stable until the done edge.
- Done edge detected in cycle t (`manchn_done`=1, previous sample 0) → `smp_valid`/`scan_done` high in cycle t+1 for exactly one cycle.
- Done edge in cycle t → next `manchn_start` at cycle t+1+`INTER_FRAME`.
- IDLE→LAUNCH decision → `manchn_start` one cycle later.
- A `manchn_done` held high for several cycles counts as one edge. Done edges outside WAIT_DONE are ignored.

## Test plan
- Mask 8'h02, `period`=0, `scan_en` held high for one scan, with an SPI model returning frame data 16'h1111 then 16'h2222 → `chsel` sequence C400, 0000; one sample with `smp_ch`=1, `smp_data`=16'h2222, plus `scan_done`.
- Mask 8'hA5, model returning 1..5 → `chsel` sequence C000, C800, D400, DC00, 0000; samples (0,2), (2,3), (5,4), (7,5); `scan_done` on the last sample.
- Mask 8'h00, `scan_en`=1 for 500 cycles → `manchn_start` never asserted, `busy`=0, no `smp_valid`.
- Mask 8'h01, `period`=5000 → consecutive `manchn_start` pulses that open scans are exactly 5000 cycles apart. With `period`=10, scans run back-to-back with one cycle after `scan_done`.
- Model never asserts done → `err_timeout`=1 exactly `TIMEOUT` cycles after start, `busy` drops, no `smp_valid`. The next scan proceeds normally.
- `rst` pulse during WAIT_DONE → all outputs at reset values on the next cycle. Separately, `scan_en` dropped during frame 2 of mask 8'h0F → all 4 samples and `scan_done` still produced, then IDLE.
